usb_tx_packet_serializer: RTL and testbench
===========================================

// Module: usb_tx_packet_serializer
// PURPOSE
//  Transmit end of the USB packet path. Takes a parallel PID, up to MAX_BYTES data bytes and a CRC16.
//  Emits SYNC, PID, data and CRC16 serially, each field LSB-first on the wire.
//  Applies bit stuffing and NRZI, then ends with EOP on d_plus/d_minus (full-speed levels).
//  Sits between the packet controller and the bus driver; one wire bit per bit_tick strobe.
// PARAMETERS
//  MAX_BYTES  8  max data payload bytes; data port is 8*MAX_BYTES wide
// PORTS
//  clk         in   1        system clock, rising edge
//  n_rst       in   1        asynchronous, active-low reset
//  bit_tick    in   1        one-clk strobe per USB bit period (from bit timer)
//  tx_start    in   1        request; sampled only in IDLE
//  has_data    in   1        0 = PID-only (handshake) packet; 1 = data packet (+CRC16)
//  pid         in   8        PID byte; bit 0 sent first
//  data        in   8*MAX_BYTES  payload; byte k = data[8k+7:8k], byte 0 first, LSB first
//  data_bytes  in   4        payload byte count, 0..MAX_BYTES (larger values clamp to MAX_BYTES)
//  crc16_in    in   16       externally supplied CRC, already in wire order, bit 0 first
//  busy        out  1        high from the cycle after acceptance until tx_done
//  tx_done     out  1        one-clk pulse after the final EOP J bit
//  d_plus      out  1        bus D+ (registered)
//  d_minus     out  1        bus D- (registered)
// BEHAVIOUR
//  Reset values: d_plus=1, d_minus=0 (idle J), busy=0, tx_done=0, FSM=IDLE, ones_cnt=0.
//  Accept: IDLE & tx_start at a clk edge -> latch pid/data/data_bytes/has_data/crc16_in; busy=1 next cycle.
//  tx_start while busy is ignored; latched fields are not affected.
//  Line outputs and bit pointer change only on clk edges with bit_tick=1.
//  Gaps between ticks hold all line state. First SYNC bit appears on the first tick after acceptance.
//  FSM: IDLE -> SYNC(8) -> PID(8) -> [has_data: DATA(8*data_bytes) -> CRC(16)] -> EOP_SE0(2) -> EOP_J(1) -> IDLE.
//  With data_bytes=0, DATA is skipped and CRC is still sent.
//  SYNC = 8'h80 sent LSB first (seven 0s, then a 1).
//  NRZI: raw 0 toggles J<->K; raw 1 holds the level. J = (1,0), K = (0,1).
//  Stuffing: ones_cnt counts consecutive raw 1s from SYNC's final 1 through the last CRC bit.
//   - When ones_cnt reaches 6, the next tick sends a stuffed 0 (toggle), holds the bit pointer, and clears ones_cnt.
//   - A stuff due after the last CRC bit is sent before EOP.
//   - Any raw 0 clears ones_cnt.
//  EOP: d_plus=d_minus=0 for 2 ticks, then J for 1 tick. tx_done pulses on the clk after that J tick.
//  tx_done and busy=0 occur together; FSM is IDLE the same cycle, so a new tx_start is accepted immediately.
//  Reset mid-packet: lines return to J asynchronously; no EOP is generated; no tx_done.
// CONFIGURATION
//  USB_TX_CRC_GEN_EN defined:
//   - CRC16 is computed internally over the data bits as sent (pre-stuffing).
//   - c=16'hFFFF at the start of DATA; per bit b: fb = b^c[15]; c = {c[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
//   - CRC field sends ~c[15] first, down to ~c[0].
//   - crc16_in is ignored.
//  Not defined: CRC field sends latched crc16_in[0] first through crc16_in[15]; no CRC logic is instantiated.
// STRUCTURE
//  Package usb_tx_pkg: state enum (IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J), SYNC_BYTE=8'h80,
//   CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, STUFF_LIMIT=6, J/K level constants.
//  Sub-module usb_crc16_gen (clear, bit_valid, bit_in -> crc[15:0]); instantiated only under USB_TX_CRC_GEN_EN.
// TESTING
//  Bench uses a reference NRZI decoder and destuffer; bit_tick every 4 clks unless noted.
//  1 ACK: pid=8'hD2, has_data=0 -> raw 0000000 1, 0100 1011; SE0,SE0,J; 19 ticks; tx_done once.
//  2 Stuffing: pid=8'hC3, data=8'hFF, data_bytes=1, crc16_in=16'h0000 (macro off)
//     -> stuffed 0 after the 4th data bit; 8+8+9+16+3 = 44 ticks total.
//  3 Zero-length DATA1, macro on: pid=8'h4B, has_data=1, data_bytes=0
//     -> CRC field = 16 raw 0s (line toggles every tick), then EOP.
//  4 tx_start pulsed every clk during test 1 -> no re-latch, single packet.
//     IDLE-cycle start on the tx_done clk is accepted back-to-back.
//  5 Irregular bit_tick (gaps 1..9 clks) on a 4-byte packet -> decoded bits identical to test with a fixed gap.
//  6 n_rst asserted mid-DATA -> d_plus=1, d_minus=0, busy=0 immediately; no tx_done; next packet correct.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet serializer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [2:0]  STUFF_LIMIT = 3'd6;

    // Line levels as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_crc16_gen.sv
// Serial CRC16 (poly 0x8005, init 0xFFFF) over data bits in wire order.
module usb_crc16_gen
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (bit_valid) begin
            crc <= {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx_packet_serializer.sv
// USB full-speed packet serializer: SYNC/PID/DATA/CRC16 with bit stuffing, NRZI and EOP.
// Define USB_TX_CRC_GEN_EN to compute the CRC16 internally instead of sending crc16_in.
module usb_tx_packet_serializer
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES = 8
)
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   bit_tick,
    input  logic                   tx_start,
    input  logic                   has_data,
    input  logic [7:0]             pid,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [3:0]             data_bytes,
    input  logic [15:0]            crc16_in,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   d_plus,
    output logic                   d_minus
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int CW = $clog2(DW + 17);
    localparam logic [4:0] MAXB = 5'(MAX_BYTES);

    tx_state_t      state, state_nx, after_pid;
    logic [CW-1:0]  bit_cnt, field_len;
    logic [2:0]     ones_cnt;
    logic [7:0]     pid_q;
    logic [DW-1:0]  data_sr;
    logic [3:0]     nbytes_q, nbytes_in;
    logic           has_data_q;
    logic [1:0]     line_q;
    logic           tx_done_q;
    logic           accept, stuff_now, emit, raw_bit, crc_bit, field_last;

    assign nbytes_in = ({1'b0, data_bytes} > MAXB) ? MAXB[3:0] : data_bytes;

`ifdef USB_TX_CRC_GEN_EN
    logic [15:0] crc_val;
    logic        unused_crc16_in;

    assign unused_crc16_in = ^crc16_in;

    usb_crc16_gen u_crc16_gen (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (accept),
        .bit_valid (emit && (state == DATA)),
        .bit_in    (data_sr[0]),
        .crc       (crc_val)
    );

    // The CRC field goes out inverted, MSB of the register first.
    assign crc_bit = ~crc_val[4'd15 - bit_cnt[3:0]];
`else
    logic [15:0] crc_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= '0;
        end else if (accept) begin
            crc_q <= crc16_in;
        end
    end

    assign crc_bit = crc_q[bit_cnt[3:0]];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A pending stuff bit always pre-empts the field bit, including one due right before EOP.
    always_comb begin
        accept    = (state == IDLE) && tx_start;
        after_pid = has_data_q ? ((nbytes_q == 4'd0) ? CRC : DATA) : EOP_SE0;
        raw_bit   = 1'b1;
        field_len = CW'(8);
        case (state)
            SYNC: raw_bit = SYNC_BYTE[bit_cnt[2:0]];
            PID:  raw_bit = pid_q[bit_cnt[2:0]];
            DATA: begin
                raw_bit   = data_sr[0];
                field_len = CW'({nbytes_q, 3'b000});
            end
            CRC: begin
                raw_bit   = crc_bit;
                field_len = CW'(16);
            end
            default: ;
        endcase
        field_last = (bit_cnt == field_len - CW'(1));
        stuff_now  = bit_tick && (ones_cnt == STUFF_LIMIT)
                     && (state inside {PID, DATA, CRC, EOP_SE0});
        emit       = bit_tick && !stuff_now && (state inside {SYNC, PID, DATA, CRC});

        state_nx = state;
        case (state)
            IDLE:    if (tx_start) state_nx = SYNC;
            SYNC:    if (emit && field_last) state_nx = PID;
            PID:     if (emit && field_last) state_nx = after_pid;
            DATA:    if (emit && field_last) state_nx = CRC;
            CRC:     if (emit && field_last) state_nx = EOP_SE0;
            EOP_SE0: if (bit_tick && !stuff_now && bit_cnt[0]) state_nx = EOP_J;
            EOP_J:   if (bit_tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            pid_q      <= '0;
            data_sr    <= '0;
            nbytes_q   <= '0;
            has_data_q <= 1'b0;
            line_q     <= LINE_J;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (accept) begin
                pid_q      <= pid;
                data_sr    <= data;
                nbytes_q   <= nbytes_in;
                has_data_q <= has_data;
                bit_cnt    <= '0;
                ones_cnt   <= '0;
            end else if (stuff_now) begin
                line_q   <= nrzi_toggle(line_q);
                ones_cnt <= '0;
            end else if (emit) begin
                if (!raw_bit) begin
                    line_q <= nrzi_toggle(line_q);
                end
                ones_cnt <= raw_bit ? ones_cnt + 3'd1 : 3'd0;
                bit_cnt  <= (state_nx != state) ? '0 : bit_cnt + CW'(1);
                if (state == DATA) begin
                    data_sr <= data_sr >> 1;
                end
            end else if (bit_tick && (state == EOP_SE0)) begin
                line_q   <= LINE_SE0;
                ones_cnt <= '0;
                bit_cnt  <= (state_nx != state) ? '0 : bit_cnt + CW'(1);
            end else if (bit_tick && (state == EOP_J)) begin
                line_q    <= LINE_J;
                tx_done_q <= 1'b1;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign tx_done = tx_done_q;
    assign d_plus  = line_q[1];
    assign d_minus = line_q[0];

endmodule

// File: tb/tb_usb_tx_packet_serializer.sv
// Randomized bench for usb_tx_packet_serializer: per-cycle queue model plus NRZI decode/destuff of each packet.
module tb_usb_tx_packet_serializer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        bit_tick;
    logic        tx_start;
    logic        has_data;
    logic [7:0]  pid;
    logic [63:0] data;
    logic [3:0]  data_bytes;
    logic [15:0] crc16_in;
    logic        busy, tx_done, d_plus, d_minus;

    int vectors = 0;
    int miscompares = 0;

    usb_tx_packet_serializer #(.MAX_BYTES(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_tick   (bit_tick),
        .tx_start   (tx_start),
        .has_data   (has_data),
        .pid        (pid),
        .data       (data),
        .data_bytes (data_bytes),
        .crc16_in   (crc16_in),
        .busy       (busy),
        .tx_done    (tx_done),
        .d_plus     (d_plus),
        .d_minus    (d_minus)
    );

    always #5 clk = ~clk;

    // Expected packet built from the field rules: raw bits, then stuffing, NRZI, EOP.
    bit         bld_raw[$];
    logic [1:0] bld_wire[$];

    function automatic void build_expected(input logic [7:0] p, input logic hd, input logic [63:0] d,
                                           input logic [3:0] nb_in, input logic [15:0] crc_in);
        int         nb;
        int         ones;
        logic [15:0] c;
        logic [1:0] line;
        bit         b;
        bld_raw.delete();
        bld_wire.delete();
        nb = (nb_in > 4'd8) ? 8 : int'(nb_in);
        for (int i = 0; i < 7; i++) bld_raw.push_back(1'b0);
        bld_raw.push_back(1'b1);
        for (int i = 0; i < 8; i++) bld_raw.push_back(p[i]);
        if (hd) begin
            c = 16'hFFFF;
            for (int i = 0; i < 8 * nb; i++) begin
                b = d[i];
                bld_raw.push_back(b);
                c = (b ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
            end
            for (int i = 0; i < 16; i++) begin
`ifdef USB_TX_CRC_GEN_EN
                bld_raw.push_back(~c[15 - i]);
`else
                bld_raw.push_back(crc_in[i]);
`endif
            end
        end
        line = 2'b10;
        ones = 0;
        foreach (bld_raw[i]) begin
            b = bld_raw[i];
            if (!b) line = ~line;
            bld_wire.push_back(line);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                line = ~line;
                bld_wire.push_back(line);
                ones = 0;
            end
        end
        bld_wire.push_back(2'b00);
        bld_wire.push_back(2'b00);
        bld_wire.push_back(2'b10);
    endfunction

    // Cycle model: one wire symbol per tick after acceptance; done when the queue drains.
    bit         m_raw[$];
    logic [1:0] m_wire[$];
    logic [1:0] m_line = 2'b10;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_ticked = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_line = 2'b10;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ticked = 1'b0;
            m_wire.delete();
        end else begin
            m_done = 1'b0;
            m_ticked = 1'b0;
            if (!m_busy) begin
                if (tx_start) begin
                    build_expected(pid, has_data, data, data_bytes, crc16_in);
                    m_wire = bld_wire;
                    m_raw  = bld_raw;
                    m_busy = 1'b1;
                end
            end else if (bit_tick) begin
                m_line = m_wire.pop_front();
                m_ticked = 1'b1;
                if (m_wire.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Bit-tick generator: fixed period of 4 clocks, or random gaps of 1..9 clocks.
    bit gap_mode = 1'b0;
    int cur_gap = 4;
    int tick_cnt = 0;

    initial begin
        bit_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= cur_gap - 1) begin
                bit_tick = 1'b1;
                tick_cnt = 0;
                cur_gap = gap_mode ? int'($urandom_range(1, 9)) : 4;
            end else begin
                bit_tick = 1'b0;
                tick_cnt++;
            end
        end
    end

    // Reference receiver: NRZI-decode and destuff the captured symbols, then require the raw stream and EOP.
    logic [1:0] cap_q[$];

    function automatic void check_decode();
        logic [1:0] last;
        int         ones;
        int         k;
        bit         b;
        bit         ok;
        bit         dec[$];
        last = 2'b10;
        ones = 0;
        ok = 1'b1;
        k = 0;
        while (k < cap_q.size() && cap_q[k] != 2'b00) begin
            b = (cap_q[k] == last);
            last = cap_q[k];
            if (ones == 6) begin
                if (b) ok = 1'b0;
                ones = 0;
            end else begin
                dec.push_back(b);
                ones = b ? ones + 1 : 0;
            end
            k++;
        end
        if (cap_q.size() != k + 3) ok = 1'b0;
        else if (cap_q[k] != 2'b00 || cap_q[k + 1] != 2'b00 || cap_q[k + 2] != 2'b10) ok = 1'b0;
        if (dec.size() != m_raw.size()) ok = 1'b0;
        else foreach (dec[i]) if (dec[i] != m_raw[i]) ok = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL decode: got %0d decoded bits from %0d symbols, required %0d raw bits plus SE0,SE0,J",
                     dec.size(), cap_q.size(), m_raw.size());
        end
        cap_q.delete();
    endfunction

    always @(negedge clk) begin
        vectors++;
        if ({d_plus, d_minus} !== m_line || busy !== m_busy || tx_done !== m_done) begin
            miscompares++;
            $display("[TB] FAIL cycle @%0t: dut line=%b busy=%b tx_done=%b, required line=%b busy=%b tx_done=%b",
                     $time, {d_plus, d_minus}, busy, tx_done, m_line, m_busy, m_done);
        end
        if (!n_rst) begin
            cap_q.delete();
        end else begin
            if (m_ticked) cap_q.push_back({d_plus, d_minus});
            if (m_done) check_decode();
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        pid        = 8'($urandom);
        has_data   = 1'($urandom);
        data       = {$urandom, $urandom};
        data_bytes = 4'($urandom_range(0, 15));
        crc16_in   = 16'($urandom);
    endtask

    task automatic wait_done(input bit hold);
        int n;
        n = 0;
        while (!m_done && n < 20000) begin
            if (hold) scramble_inputs();
            @(negedge clk);
            n++;
        end
        if (!m_done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: no packet end after %0d cycles, required one", n);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] p, input logic hd, input logic [63:0] d,
                                  input logic [3:0] nb, input logic [15:0] crc, input bit hold);
        @(negedge clk);
        pid = p;
        has_data = hd;
        data = d;
        data_bytes = nb;
        crc16_in = crc;
        tx_start = 1'b1;
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        wait_done(hold);
    endtask

    function automatic logic [63:0] rand_payload();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            d[8 * i +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        end
        return d;
    endfunction

    initial begin
        logic [18:0] dpv;
        int          toggles;
        n_rst = 1'b0;
        tx_start = 1'b0;
        has_data = 1'b0;
        pid = '0;
        data = '0;
        data_bytes = '0;
        crc16_in = '0;

        // Pin the model to hand-derived sequences.
        build_expected(8'hD2, 1'b0, 64'h0, 4'd0, 16'h0);
        check_output("ack_ticks", bld_wire.size(), 19);
        for (int i = 0; i < 19; i++) dpv[i] = bld_wire[i][1];
        check_output("ack_dplus", int'(dpv), int'(19'b100_00011011_00101010));
        build_expected(8'hC3, 1'b1, 64'hFF, 4'd1, 16'h0000);
        check_output("stuff_raw_len", bld_raw.size(), 40);
        check_output("stuff_hold", int'(bld_wire[19] == bld_wire[18]), 1);
        check_output("stuff_toggle", int'(bld_wire[20] != bld_wire[19]), 1);
`ifndef USB_TX_CRC_GEN_EN
        check_output("stuff_ticks", bld_wire.size(), 44);
`endif
        build_expected(8'h4B, 1'b1, 64'h0, 4'd0, 16'h0000);
        check_output("zlp_ticks", bld_wire.size(), 35);
        toggles = 0;
        for (int i = 16; i < 32; i++) if (bld_wire[i] != bld_wire[i - 1]) toggles++;
        check_output("zlp_crc_toggles", toggles, 16);

        repeat (3) @(negedge clk);
        check_output("reset_dplus", int'(d_plus), 1);
        check_output("reset_dminus", int'(d_minus), 0);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        // ACK with tx_start held and inputs churning, then back-to-back acceptance.
        apply_stimulus(8'hD2, 1'b0, 64'h0, 4'd0, 16'h0, 1'b1);
        @(negedge clk);
        tx_start = 1'b0;
        wait_done(1'b0);

        apply_stimulus(8'hC3, 1'b1, 64'hFF, 4'd1, 16'h0000, 1'b0);
        apply_stimulus(8'h4B, 1'b1, 64'h0, 4'd0, 16'h0000, 1'b0);
        apply_stimulus(8'hC3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 16'hFFFF, 1'b0);

        // Same 4-byte packet with fixed and irregular tick spacing.
        apply_stimulus(8'hC3, 1'b1, 64'h0000_0000_7EFF_A5FF, 4'd4, 16'hF0FF, 1'b0);
        gap_mode = 1'b1;
        apply_stimulus(8'hC3, 1'b1, 64'h0000_0000_7EFF_A5FF, 4'd4, 16'hF0FF, 1'b0);

        for (int k = 0; k < 24; k++) begin
            gap_mode = (k % 3 == 2);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            apply_stimulus(8'($urandom), 1'($urandom_range(0, 3) != 0), rand_payload(),
                           4'($urandom_range(0, 10)), 16'($urandom), 1'b0);
        end
        gap_mode = 1'b0;

        // Reset in the middle of DATA.
        @(negedge clk);
        pid = 8'hC3;
        has_data = 1'b1;
        data = 64'h0000_0000_1234_5678;
        data_bytes = 4'd4;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (100) @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check_output("rst_mid_dplus", int'(d_plus), 1);
        check_output("rst_mid_dminus", int'(d_minus), 0);
        check_output("rst_mid_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        apply_stimulus(8'hD2, 1'b0, 64'h0, 4'd0, 16'h0, 1'b0);
        apply_stimulus(8'h4B, 1'b1, rand_payload(), 4'd3, 16'($urandom), 1'b0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
